// File: rtl/clk_pkg.sv
// Shared types and limits for the BCD time loader: FSM states, digit count,
// and the packed hour/minute/second record.
package clk_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        CONVERT = 2'd1,
        CHECK   = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int NUM_DIGITS  = 6;
    localparam int MIN_SEC_MAX = 59;

    typedef struct packed {
        logic [6:0] hr;
        logic [6:0] min;
        logic [6:0] sec;
    } hms_t;

endpackage

// File: rtl/bcd2bin.sv
// Two-digit BCD to binary: tens*10 + units, computed as tens*8 + tens*2 + units.
module bcd2bin (
    input  logic [3:0] tens,
    input  logic [3:0] units,
    output logic [6:0] bin
);

    assign bin = {tens, 3'b000} + {2'b00, tens, 1'b0} + {3'b000, units};

endmodule

// File: rtl/bcd_time_loader.sv
// Collects six BCD digits (hh mm ss), converts each field through one shared
// bcd2bin over three cycles, range-checks the result and loads it or flags err.
module bcd_time_loader
    import clk_pkg::*;
#(
    parameter int HR_MAX = 23
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       digit_valid,
    input  logic [3:0] digit,
    input  logic       cancel,
    output logic [6:0] Hr,
    output logic [6:0] Min,
    output logic [6:0] Sec,
    output logic       ld,
    output logic       err,
    output logic       busy,
    output logic [2:0] pos
);

    state_t                         state;
    logic [NUM_DIGITS-1:0][3:0]     digs;
    logic [1:0]                     step;
    hms_t                           res;
    logic [3:0]                     tens, units;
    logic [6:0]                     bin;
    logic                           bad;

    // Field select for the shared converter: step 0/1/2 -> hr/min/sec digit pairs.
    always_comb begin
        tens  = digs[0];
        units = digs[1];
        case (step)
            2'd1: begin tens = digs[2]; units = digs[3]; end
            2'd2: begin tens = digs[4]; units = digs[5]; end
            default: ;
        endcase
    end

    bcd2bin u_bcd2bin (
        .tens  (tens),
        .units (units),
        .bin   (bin)
    );

    assign bad = (res.hr  > 7'(HR_MAX)) ||
                 (res.min > 7'(MIN_SEC_MAX)) ||
                 (res.sec > 7'(MIN_SEC_MAX));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= COLLECT;
            pos   <= '0;
            digs  <= '0;
            step  <= '0;
            res   <= '0;
            Hr    <= '0;
            Min   <= '0;
            Sec   <= '0;
            ld    <= 1'b0;
            err   <= 1'b0;
            busy  <= 1'b0;
        end else begin
            ld  <= 1'b0;
            err <= 1'b0;
            case (state)
                COLLECT: begin
                    if (cancel) begin
                        pos  <= '0;
                        digs <= '0;
                    end else if (digit_valid) begin
                        if (digit > 4'd9) begin
                            err  <= 1'b1;
                            pos  <= '0;
                            digs <= '0;
                        end else begin
                            digs[pos] <= digit;
                            if (pos == 3'(NUM_DIGITS - 1)) begin
                                // pos parks at 0 while busy so the next entry starts clean
                                pos   <= '0;
                                step  <= '0;
                                busy  <= 1'b1;
                                state <= CONVERT;
                            end else begin
                                pos <= pos + 3'd1;
                            end
                        end
                    end
                end
                CONVERT: begin
                    step <= step + 2'd1;
                    case (step)
                        2'd0: res.hr  <= bin;
                        2'd1: res.min <= bin;
                        default: begin
                            res.sec <= bin;
                            state   <= CHECK;
                        end
                    endcase
                end
                CHECK: begin
                    if (bad) begin
                        err <= 1'b1;
                    end else begin
                        ld  <= 1'b1;
                        Hr  <= res.hr;
                        Min <= res.min;
                        Sec <= res.sec;
                    end
                    state <= DONE;
                end
                DONE: begin
                    digs  <= '0;
                    busy  <= 1'b0;
                    state <= COLLECT;
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_time_loader.sv
// Directed bench for bcd_time_loader: a reference model predicts ld/err events
// into a scoreboard queue; outputs are compared every cycle on the falling edge.
module tb_bcd_time_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       digit_valid = 1'b0;
    logic [3:0] digit = 4'd0;
    logic       cancel = 1'b0;
    logic [6:0] Hr, Min, Sec;
    logic       ld, err, busy;
    logic [2:0] pos;

    bcd_time_loader #(.HR_MAX(23)) dut (
        .clk         (clk),
        .rst         (rst),
        .digit_valid (digit_valid),
        .digit       (digit),
        .cancel      (cancel),
        .Hr          (Hr),
        .Min         (Min),
        .Sec         (Sec),
        .ld          (ld),
        .err         (err),
        .busy        (busy),
        .pos         (pos)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit kind;   // 1 = ld, 0 = err
        int cyc;
        int hr;
        int min;
        int sec;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   mhr = 0, mmin = 0, msec = 0;
    int   mpos = 0;
    int   md[6];
    int   bf = 1, bt = 0;   // expected busy window [bf, bt] in cycle numbers

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_outputs();
        exp_t e;
        if (q.size() > 0 && q[0].cyc == cyc) begin
            e = q.pop_front();
            chk("ld_event", {31'd0, ld}, {31'd0, e.kind});
            chk("err_event", {31'd0, err}, {31'd0, !e.kind});
            if (e.kind) begin
                mhr = e.hr; mmin = e.min; msec = e.sec;
            end
        end else begin
            chk("ld_quiet", {31'd0, ld}, 32'd0);
            chk("err_quiet", {31'd0, err}, 32'd0);
        end
        chk("Hr", {25'd0, Hr}, mhr);
        chk("Min", {25'd0, Min}, mmin);
        chk("Sec", {25'd0, Sec}, msec);
        chk("pos", {29'd0, pos}, mpos);
        chk("busy", {31'd0, busy}, (cyc >= bf && cyc <= bt) ? 32'd1 : 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Drive one digit (optionally with cancel) for one clock and update the model.
    task automatic send(input int d, input bit c);
        exp_t e;
        bit   is_busy;
        int   h, m, s;
        is_busy = (cyc >= bf && cyc <= bt);
        if (!is_busy) begin
            if (c) begin
                mpos = 0;
            end else if (d > 9) begin
                e.kind = 1'b0; e.cyc = cyc + 1; e.hr = 0; e.min = 0; e.sec = 0;
                q.push_back(e);
                mpos = 0;
            end else begin
                md[mpos] = d;
                if (mpos == 5) begin
                    h = md[0] * 10 + md[1];
                    m = md[2] * 10 + md[3];
                    s = md[4] * 10 + md[5];
                    e.kind = (h <= 23 && m <= 59 && s <= 59);
                    e.cyc = cyc + 5; e.hr = h; e.min = m; e.sec = s;
                    q.push_back(e);
                    bf = cyc + 1;
                    bt = cyc + 5;
                    mpos = 0;
                end else begin
                    mpos++;
                end
            end
        end
        digit_valid = 1'b1;
        digit = 4'(d);
        cancel = c;
        tick();
        digit_valid = 1'b0;
        digit = 4'd0;
        cancel = 1'b0;
    endtask

    task automatic entry(input int d0, d1, d2, d3, d4, d5);
        send(d0, 0); send(d1, 0); send(d2, 0);
        send(d3, 0); send(d4, 0); send(d5, 0);
    endtask

    initial begin
        // reset state
        idle(2);
        rst = 1'b0;

        // valid entry 12:34:56, then first digit right after reset release
        entry(1, 2, 3, 4, 5, 6);
        idle(6);

        // hour 24 out of range: err, previous time held
        entry(2, 4, 0, 0, 0, 0);
        idle(6);

        // minute 60 rejected, then the maximum legal time
        entry(0, 9, 6, 0, 0, 0);
        idle(6);
        entry(2, 3, 5, 9, 5, 9);
        idle(6);

        // illegal digit aborts, then 01:02:03 with digits and cancel thrown at it while busy
        send(1, 0);
        send(10, 0);
        idle(1);
        entry(0, 1, 0, 2, 0, 3);
        send(7, 0);
        send(8, 1);
        send(9, 0);
        idle(4);

        // cancel beats a same-cycle digit
        send(1, 0); send(2, 0); send(3, 0);
        send(4, 1);
        idle(2);
        send(5, 0);
        send(0, 1);
        idle(2);

        // reset during conversion: nothing emerges afterwards
        entry(1, 2, 3, 4, 5, 6);
        tick();
        rst = 1'b1;
        q.delete();
        mhr = 0; mmin = 0; msec = 0;
        mpos = 0;
        bf = 1; bt = 0;
        tick();
        rst = 1'b0;
        idle(8);

        chk("scoreboard_drained", q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_time_loader.md
BCD_TIME_LOADER -- requirements
Module: bcd_time_loader

Interface
REQ-001 SHALL have parameter HR_MAX, default 23, meaning the largest legal hour value (binary).
REQ-002 SHALL have port clk, input, 1, the single system clock; all logic is rising-edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port digit_valid, input, 1, one-cycle strobe qualifying digit.
REQ-005 SHALL have port digit, input, 4, BCD digit entered by the user (0-9 legal).
REQ-006 SHALL have port cancel, input, 1, discards partial entry.
REQ-007 SHALL have port Hr, output, 7, loaded hour in binary.
REQ-008 SHALL have port Min, output, 7, loaded minute in binary.
REQ-009 SHALL have port Sec, output, 7, loaded second in binary.
REQ-010 SHALL have port ld, output, 1, one-cycle pulse: Hr/Min/Sec carry a new valid time.
REQ-011 SHALL have port err, output, 1, one-cycle pulse: entry rejected.
REQ-012 SHALL have port busy, output, 1, high while digits are not accepted.
REQ-013 SHALL have port pos, output, 3, index 0-5 of the next digit expected.

Function
REQ-014 SHALL implement states COLLECT, CONVERT, CHECK, DONE; all outputs registered.
REQ-015 SHALL accept digits in order Hr tens, Hr units, Min tens, Min units, Sec tens, Sec units (pos 0..5).
REQ-016 In COLLECT, digit_valid with digit<=9 SHALL store the digit at pos and increment pos.
REQ-017 In COLLECT, digit_valid with digit>9 SHALL pulse err next cycle, clear pos to 0 and discard stored digits.
REQ-018 cancel in COLLECT SHALL clear pos to 0 without err; cancel wins over a same-cycle digit_valid.
REQ-019 Accepting the digit at pos 5 (cycle T) SHALL move to CONVERT at T+1 with busy=1 from T+1.
REQ-020 CONVERT SHALL take 3 cycles, one field per cycle (hr, min, sec), value = tens*8 + tens*2 + units, 7-bit result.
REQ-021 CHECK (cycle T+4) SHALL reject if hr>HR_MAX, min>59 or sec>59.
REQ-022 On pass, DONE (cycle T+5) SHALL assert ld for exactly one cycle with Hr/Min/Sec updated in that same cycle.
REQ-023 On fail, err SHALL pulse at T+5; Hr/Min/Sec SHALL hold previous values; no ld.
REQ-024 After DONE/err, the FSM SHALL return to COLLECT at T+6 with pos=0, busy=0.
REQ-025 digit_valid and cancel while busy=1 SHALL be ignored with no side effect.
REQ-026 ld and err SHALL never be high in the same cycle.
REQ-027 Hr/Min/Sec SHALL change only in a cycle where ld=1.

Reset
REQ-028 rst SHALL asynchronously force state COLLECT, pos=0, stored digits 0, Hr=Min=Sec=0, ld=0, err=0, busy=0.
REQ-029 rst asserted mid-CONVERT/CHECK SHALL abort the entry with no ld or err after release.
REQ-030 First digit SHALL be accepted on the first clk edge after rst deasserts.

Structure
REQ-031 State encoding, digit count (6) and MIN_SEC_MAX (59) SHALL live in shared package clk_pkg.
REQ-032 The two-digit BCD-to-binary conversion SHALL be sub-module bcd2bin (tens, units in; 7-bit binary out), instantiated once and time-shared across CONVERT cycles.

Verification
REQ-033 Digits 1,2,3,4,5,6 -> ld pulse 5 cycles after last digit, Hr=12, Min=34, Sec=56, err=0.
REQ-034 Digits 2,4,0,0,0,0 (HR_MAX=23) -> err pulse at T+5, no ld, Hr/Min/Sec keep prior 12/34/56.
REQ-035 Digits 0,9,6,0,0,0 -> err (min=60); then 2,3,5,9,5,9 -> ld, Hr=23, Min=59, Sec=59.
REQ-036 Digits 1,0xA -> err next cycle, pos=0; digits 0,1,0,2,0,3 -> ld, Hr=1, Min=2, Sec=3.
REQ-037 Digits 1,2,3 then cancel with simultaneous digit_valid -> pos=0, no err; digits during busy ignored, pos stays 0.
REQ-038 rst pulsed at T+2 of a valid entry -> Hr=Min=Sec=0, no ld/err after release, pos=0.
